// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD read/write controllers.
//   - Control_in command codes for the writer (05/06) and reader (07/08/09)
//   - status codes reported on the status port
//   - reader FSM state encoding
package lcd_pkg;

   localparam logic [7:0] CTRL_IDLE      = 8'h00;
   localparam logic [7:0] CTRL_WR_CMD    = 8'h05;
   localparam logic [7:0] CTRL_WR_DATA   = 8'h06;
   localparam logic [7:0] CTRL_RD_STATUS = 8'h07;
   localparam logic [7:0] CTRL_RD_DATA   = 8'h08;
   localparam logic [7:0] CTRL_POLL_BUSY = 8'h09;

   localparam logic [7:0] ST_READY      = 8'h00;
   localparam logic [7:0] ST_DONE       = 8'h01;
   localparam logic [7:0] ST_WR_CMD     = 8'h04;
   localparam logic [7:0] ST_WR_DATA    = 8'h08;
   localparam logic [7:0] ST_RD_BUSY    = 8'h0A;
   localparam logic [7:0] ST_INVALID    = 8'hE0;
   localparam logic [7:0] ST_POLL_TMOUT = 8'hE1;

   typedef enum logic [2:0] {
      RD_IDLE,
      RD_SETUP,
      RD_EHIGH,
      RD_SAMPLE,
      RD_HOLD,
      RD_DONE,
      RD_WAIT_REL
   } rd_state_t;

   function automatic logic is_read_cmd(input logic [7:0] c);
      return (c == CTRL_RD_STATUS) || (c == CTRL_RD_DATA) || (c == CTRL_POLL_BUSY);
   endfunction

endpackage

// File: rtl/lcd_timer.sv
// 8-bit down-counter used to time LCD bus phases.
//   clk, reset   : clock, synchronous active-low reset
//   load         : load load_val (takes priority over counting)
//   en           : count down while nonzero
//   load_val     : value loaded; a phase lasts load_val+1 cycles
//   expired      : terminal count (counter at zero)
module lcd_timer (
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       en,
   input  logic [7:0] load_val,
   output logic       expired
);

   logic [7:0] cnt_q;

   always_ff @(posedge clk) begin
      if (!reset)
         cnt_q <= '0;
      else if (load)
         cnt_q <= load_val;
      else if (en && (cnt_q != 8'd0))
         cnt_q <= cnt_q - 8'd1;
   end

   assign expired = (cnt_q == 8'd0);

endmodule

// File: rtl/lcd_reader.sv
// HD44780-style read controller: status read, data read and busy-poll.
//   clk, reset  : clock, synchronous active-low reset
//   Control_in  : command (00 idle, 07 status, 08 data, 09 poll busy)
//   Data_lcd    : LCD data bus, valid while E is high
//   RS, RW, E   : LCD control pins (RW=1 only during a read cycle)
//   Data_out    : last captured byte
//   busy_flag   : bit 7 of last status read
//   addr_cnt    : bits 6:0 of last status read
//   status      : 00 ready, 0A busy, 01 done, E0 invalid, E1 poll timeout
//   sel_out     : completed-command counter (wraps)
//
// state       | meaning
// ------------+-----------------------------------------------
// RD_IDLE     | waiting for a command
// RD_SETUP    | RS/RW settled, address setup before E rises
// RD_EHIGH    | E high, TPW cycles
// RD_SAMPLE   | last E-high cycle; bus captured and E drops
// RD_HOLD     | E low, TCYC cycles before next cycle/finish
// RD_DONE     | report completion, release bus
// RD_WAIT_REL | hold status until Control_in returns to 00
module lcd_reader
   import lcd_pkg::*;
#(
   parameter int TPW      = 8,
   parameter int TCYC     = 65,
   parameter int MAX_POLL = 255
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] Control_in,
   input  logic [7:0] Data_lcd,
   output logic       RS,
   output logic       RW,
   output logic       E,
   output logic [7:0] Data_out,
   output logic       busy_flag,
   output logic [6:0] addr_cnt,
   output logic [7:0] status,
   output logic [2:0] sel_out
);

   // Timer phase lasts load_val+1 cycles, hence the -1.
   localparam logic [7:0] TPW_LOAD   = 8'(TPW - 1);
   localparam logic [7:0] TCYC_LOAD  = 8'(TCYC - 1);
   localparam logic [7:0] MAX_POLL_L = 8'(MAX_POLL);

   rd_state_t  state_q, state_d;
   logic [7:0] cmd_q;
   logic [7:0] poll_cnt_q;
   logic       tmr_load;
   logic [7:0] tmr_val;
   logic       tmr_en;
   logic       tmr_expired;

   lcd_timer u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .en       (tmr_en),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset)
         state_q <= RD_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state_q)
         RD_IDLE: begin
            if (is_read_cmd(Control_in))
               state_d = RD_SETUP;
         end
         RD_SETUP: begin
            state_d  = RD_EHIGH;
            tmr_load = 1'b1;
            tmr_val  = TPW_LOAD;
         end
         RD_EHIGH: begin
            if (tmr_expired)
               state_d = RD_SAMPLE;
         end
         RD_SAMPLE: begin
            state_d  = RD_HOLD;
            tmr_load = 1'b1;
            tmr_val  = TCYC_LOAD;
         end
         RD_HOLD: begin
            if (tmr_expired) begin
               // busy_flag already reflects the byte captured in SAMPLE
               if ((cmd_q != CTRL_POLL_BUSY) || !busy_flag)
                  state_d = RD_DONE;
               else if (poll_cnt_q < MAX_POLL_L)
                  state_d = RD_SETUP;
               else
                  state_d = RD_WAIT_REL;
            end
         end
         RD_DONE: state_d = RD_WAIT_REL;
         RD_WAIT_REL: begin
            if (Control_in == CTRL_IDLE)
               state_d = RD_IDLE;
         end
         default: state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      tmr_en = (state_q == RD_EHIGH) || (state_q == RD_HOLD);
      RW     = (state_q == RD_SETUP) || (state_q == RD_EHIGH) ||
               (state_q == RD_SAMPLE) || (state_q == RD_HOLD);
      RS     = RW && (cmd_q == CTRL_RD_DATA);
      E      = (state_q == RD_EHIGH) || (state_q == RD_SAMPLE);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         cmd_q      <= CTRL_IDLE;
         poll_cnt_q <= '0;
         Data_out   <= '0;
         busy_flag  <= 1'b0;
         addr_cnt   <= '0;
         status     <= ST_READY;
         sel_out    <= '0;
      end else begin
         case (state_q)
            RD_IDLE: begin
               if (is_read_cmd(Control_in)) begin
                  cmd_q      <= Control_in;
                  poll_cnt_q <= '0;
                  status     <= ST_RD_BUSY;
               end else if (Control_in == CTRL_IDLE) begin
                  status <= ST_READY;
               end else begin
                  status <= ST_INVALID;
               end
            end
            RD_SAMPLE: begin
               Data_out <= Data_lcd;
               if (cmd_q != CTRL_RD_DATA) begin
                  busy_flag <= Data_lcd[7];
                  addr_cnt  <= Data_lcd[6:0];
               end
            end
            RD_HOLD: begin
               if (state_d == RD_SETUP)
                  poll_cnt_q <= poll_cnt_q + 8'd1;
               else if (state_d == RD_WAIT_REL) begin
                  status     <= ST_POLL_TMOUT;
                  poll_cnt_q <= '0;
               end
            end
            RD_DONE: begin
               status     <= ST_DONE;
               sel_out    <= sel_out + 3'd1;
               poll_cnt_q <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lcd_reader.sv
// Self-checking bench for lcd_reader (MAX_POLL overridden to 4).
module tb_lcd_reader;

   localparam int L_TPW      = 8;
   localparam int L_TCYC     = 65;
   localparam int L_MAX_POLL = 4;

   logic       clk;
   logic       reset;
   logic [7:0] Control_in;
   logic [7:0] Data_lcd;
   logic       RS, RW, E;
   logic [7:0] Data_out;
   logic       busy_flag;
   logic [6:0] addr_cnt;
   logic [7:0] status;
   logic [2:0] sel_out;

   lcd_reader #(.TPW(L_TPW), .TCYC(L_TCYC), .MAX_POLL(L_MAX_POLL)) dut (
      .clk        (clk),
      .reset      (reset),
      .Control_in (Control_in),
      .Data_lcd   (Data_lcd),
      .RS         (RS),
      .RW         (RW),
      .E          (E),
      .Data_out   (Data_out),
      .busy_flag  (busy_flag),
      .addr_cnt   (addr_cnt),
      .status     (status),
      .sel_out    (sel_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] status;
      logic [7:0] data;
      logic       busy;
      logic [6:0] addr;
      logic [2:0] sel;
      int         pulses;
      int         lat;
   } exp_t;

   exp_t exp_q[$];

   int n_chk  = 0;
   int n_pass = 0;

   // bus model / monitor state
   int         e_rise = 0, rd_done = 0, e_run = 0;
   int         bad_w = 0, e_norw = 0, rs_bad = 0;
   logic       e_prev = 1'b0;
   int         cfg_base = 0, cfg_n_busy = 0;
   logic [7:0] cfg_busy = 8'h00, cfg_final = 8'h00;
   logic       cfg_rs = 1'b0;

   // reference model of the registered outputs
   logic       m_busy = 1'b0;
   logic [6:0] m_addr = '0;
   logic [2:0] m_sel  = '0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Monitor E pulses and play the LCD: first cfg_n_busy reads return
   // cfg_busy, later reads return cfg_final.
   initial begin
      Data_lcd = 8'h00;
      forever begin
         @(negedge clk);
         if (E && !e_prev) e_rise++;
         if (E) e_run++;
         if (!E && e_prev) begin
            rd_done++;
            if (e_run != L_TPW + 1) bad_w++;
            e_run = 0;
         end
         if (E && !RW) e_norw++;
         if (RW && (RS !== cfg_rs)) rs_bad++;
         e_prev   = E;
         Data_lcd = ((rd_done - cfg_base) < cfg_n_busy) ? cfg_busy : cfg_final;
      end
   end

   task automatic run_cmd(input logic [7:0] cmd, input logic [7:0] mid_cmd,
                          input int n_busy, input logic [7:0] bval, input logic [7:0] fval);
      exp_t       e;
      int         reads, cyc, r0, b0, n0, s0;
      logic [7:0] v;
      logic       done;
      done  = 1'b0;
      reads = 0;
      v     = fval;
      for (int i = 0; i <= L_MAX_POLL; i++) begin
         v     = (i < n_busy) ? bval : fval;
         reads = i + 1;
         if ((cmd != 8'h09) || !v[7]) begin
            done = 1'b1;
            break;
         end
      end
      if (cmd != 8'h08) begin
         m_busy = v[7];
         m_addr = v[6:0];
      end
      if (done) m_sel = m_sel + 3'd1;
      e.status = done ? 8'h01 : 8'hE1;
      e.data   = v;
      e.busy   = m_busy;
      e.addr   = m_addr;
      e.sel    = m_sel;
      e.pulses = reads;
      e.lat    = reads * (L_TPW + L_TCYC + 2) + (done ? 1 : 0);
      exp_q.push_back(e);

      @(negedge clk);
      cfg_base   = rd_done;
      cfg_n_busy = n_busy;
      cfg_busy   = bval;
      cfg_final  = fval;
      cfg_rs     = (cmd == 8'h08);
      r0 = e_rise; b0 = bad_w; n0 = e_norw; s0 = rs_bad;
      Control_in = cmd;
      @(posedge clk); #1;
      chk("accept_status", status, 8'h0A);
      chk("accept_rw", RW, 1'b1);
      Control_in = mid_cmd;
      cyc = 0;
      while (status == 8'h0A && cyc < 3000) begin
         @(posedge clk); #1;
         cyc++;
      end
      e = exp_q.pop_front();
      chk("latency", cyc, e.lat);
      chk("status", status, e.status);
      chk("data_out", Data_out, e.data);
      chk("busy_flag", busy_flag, e.busy);
      chk("addr_cnt", addr_cnt, e.addr);
      chk("sel_out", sel_out, e.sel);
      chk("e_pulses", e_rise - r0, e.pulses);
      chk("e_width_bad", bad_w - b0, 0);
      chk("e_without_rw", e_norw - n0, 0);
      chk("rs_during_read", rs_bad - s0, 0);
      chk("rw_after", RW, 1'b0);
      chk("rs_after", RS, 1'b0);
      chk("e_after", E, 1'b0);
   endtask

   task automatic release_cmd();
      @(negedge clk);
      Control_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("release_status", status, 8'h00);
   endtask

   initial begin
      int r;
      reset      = 1'b0;
      Control_in = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rs", RS, 1'b0);
      chk("rst_rw", RW, 1'b0);
      chk("rst_e", E, 1'b0);
      chk("rst_data", Data_out, 8'h00);
      chk("rst_busy", busy_flag, 1'b0);
      chk("rst_addr", addr_cnt, 7'h00);
      chk("rst_status", status, 8'h00);
      chk("rst_sel", sel_out, 3'd0);
      @(negedge clk) reset = 1'b1;
      repeat (2) @(posedge clk);

      // status read, command held afterwards must not retrigger
      run_cmd(8'h07, 8'h07, 0, 8'h00, 8'hA5);
      r = e_rise;
      repeat (100) @(posedge clk);
      #1;
      chk("held_no_retrig", e_rise - r, 0);
      chk("held_status", status, 8'h01);
      release_cmd();

      // data read; Control_in changed mid-transaction is ignored
      run_cmd(8'h08, 8'h07, 0, 8'h00, 8'h41);
      release_cmd();

      // poll: three busy reads then ready
      run_cmd(8'h09, 8'h09, 3, 8'h80, 8'h12);
      release_cmd();

      // poll timeout: busy forever
      run_cmd(8'h09, 8'h09, 100, 8'h80, 8'h80);
      release_cmd();

      // invalid command
      r = e_rise;
      @(negedge clk) Control_in = 8'h3F;
      repeat (3) @(posedge clk);
      #1;
      chk("invalid_status", status, 8'hE0);
      chk("invalid_no_pulse", e_rise - r, 0);
      chk("invalid_rw", RW, 1'b0);
      release_cmd();

      // reset in the middle of E high
      @(negedge clk);
      cfg_rs     = 1'b0;
      Control_in = 8'h07;
      repeat (5) @(posedge clk);
      #1;
      chk("pre_rst_e", E, 1'b1);
      @(negedge clk);
      reset      = 1'b0;
      Control_in = 8'h00;
      @(posedge clk); #1;
      chk("midrst_e", E, 1'b0);
      chk("midrst_rw", RW, 1'b0);
      chk("midrst_status", status, 8'h00);
      chk("midrst_data", Data_out, 8'h00);
      chk("midrst_sel", sel_out, 3'd0);
      @(negedge clk) reset = 1'b1;
      m_busy = 1'b0;
      m_addr = '0;
      m_sel  = '0;
      @(posedge clk);
      run_cmd(8'h07, 8'h07, 0, 8'h00, 8'h3C);
      release_cmd();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
